// File: rtl/gray_frame_scheduler_if.sv
// Control and frame-buffer/pipeline signal bundle for gray_frame_scheduler.
// master: the controller/bench side. slave: the scheduler.
// No latency of its own; plain wires.
interface gray_frame_scheduler_if #(
  parameter int ADDR_W = 19
);
  logic              start;
  logic              cont;
  logic              stop;
  logic [ADDR_W-1:0] base_addr;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic              pre_frame_vsync;
  logic              pre_frame_hsync;
  logic              pre_frame_de;
  logic              busy;
  logic              frame_done;

  modport master (
    output start, cont, stop, base_addr,
    input  ram_rd_en, ram_rd_addr, pre_frame_vsync, pre_frame_hsync,
    input  pre_frame_de, busy, frame_done
  );

  modport slave (
    input  start, cont, stop, base_addr,
    output ram_rd_en, ram_rd_addr, pre_frame_vsync, pre_frame_hsync,
    output pre_frame_de, busy, frame_done
  );
endinterface

// File: rtl/gray_frame_scheduler.sv
// Frame sequencer: one frame-buffer read per active pixel, plus vsync/hsync/de.
// Latency: sync/de are registered and lag ram_rd_en by one cycle (the RAM read latency).
// No backpressure: reads are free-running in RUN; stop finishes the frame, then drains.
module gray_frame_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19,
  parameter int PIPE_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  gray_frame_scheduler_if.slave  bus
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int D_W     = $clog2(PIPE_LAT + 1) + 1;

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_SYNC_E = H_W'(H_SYNC);
  localparam logic [V_W-1:0] V_SYNC_E = V_W'(V_SYNC);
  localparam logic [H_W-1:0] H_ACT_LO = H_W'(H_SYNC + H_BP);
  localparam logic [H_W-1:0] H_ACT_HI = H_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [V_W-1:0] V_ACT_LO = V_W'(V_SYNC + V_BP);
  localparam logic [V_W-1:0] V_ACT_HI = V_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [D_W-1:0] D_LAST   = D_W'(PIPE_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [H_W-1:0]    h_cnt_q, h_cnt_d;
  logic [V_W-1:0]    v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              stop_pend_q, stop_pend_d;
  logic [D_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic              vsync_q, vsync_d;
  logic              hsync_q, hsync_d;
  logic              de_q, de_d;
  logic              frame_done_q, frame_done_d;

  logic running, hs, vs, act, rd_en, last_slot, h_last;

  // Slot decode from the registered counters; everything downstream keys off these.
  always_comb begin
    running   = (state_q == S_RUN);
    hs        = (h_cnt_q < H_SYNC_E);
    vs        = (v_cnt_q < V_SYNC_E);
    act       = (h_cnt_q >= H_ACT_LO) && (h_cnt_q < H_ACT_HI) &&
                (v_cnt_q >= V_ACT_LO) && (v_cnt_q < V_ACT_HI);
    rd_en     = running && act;
    h_last    = (h_cnt_q == H_LAST);
    last_slot = h_last && (v_cnt_q == V_LAST);
  end

  // Next-state: frame sequencing, raster counters, read address and drain timer.
  always_comb begin
    state_d      = state_q;
    h_cnt_d      = h_cnt_q;
    v_cnt_d      = v_cnt_q;
    addr_d       = addr_q;
    stop_pend_d  = stop_pend_q;
    drain_cnt_d  = drain_cnt_q;
    // Timing outputs are the registered slot terms, so they land with ram_data.
    vsync_d      = running && vs;
    hsync_d      = running && hs;
    de_d         = rd_en;
    frame_done_d = running && last_slot;

    unique case (state_q)
      S_IDLE: begin
        h_cnt_d     = '0;
        v_cnt_d     = '0;
        drain_cnt_d = '0;
        stop_pend_d = 1'b0;
        if (bus.start) begin
          state_d = S_RUN;
          addr_d  = bus.base_addr;
        end
      end
      S_RUN: begin
        if (rd_en) addr_d = addr_q + ADDR_W'(1);
        if (bus.stop) stop_pend_d = 1'b1;
        if (last_slot) begin
          h_cnt_d = '0;
          v_cnt_d = '0;
          // A stop arriving in the last slot itself still prevents the wrap.
          if (bus.cont && !stop_pend_q && !bus.stop) begin
            addr_d = bus.base_addr;
          end else begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end
        end else if (h_last) begin
          h_cnt_d = '0;
          v_cnt_d = v_cnt_q + V_W'(1);
        end else begin
          h_cnt_d = h_cnt_q + H_W'(1);
        end
      end
      S_DRAIN: begin
        // Hold off long enough for the last pixel to clear the downstream pipeline.
        h_cnt_d = '0;
        v_cnt_d = '0;
        if (drain_cnt_q == D_LAST) begin
          state_d     = S_IDLE;
          stop_pend_d = 1'b0;
        end else begin
          drain_cnt_d = drain_cnt_q + D_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any frame without a frame_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      addr_q       <= '0;
      stop_pend_q  <= 1'b0;
      drain_cnt_q  <= '0;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      de_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      addr_q       <= addr_d;
      stop_pend_q  <= stop_pend_d;
      drain_cnt_q  <= drain_cnt_d;
      vsync_q      <= vsync_d;
      hsync_q      <= hsync_d;
      de_q         <= de_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Read address is only presented while a frame is running; it reads 0 otherwise.
  always_comb begin
    bus.ram_rd_en       = rd_en;
    bus.ram_rd_addr     = running ? addr_q : '0;
    bus.pre_frame_vsync = vsync_q;
    bus.pre_frame_hsync = hsync_q;
    bus.pre_frame_de    = de_q;
    bus.busy            = (state_q != S_IDLE);
    bus.frame_done      = frame_done_q;
  end

endmodule

// File: doc/gray_frame_scheduler.md
Name: gray_frame_scheduler

Overview:
- Frame sequencer and timing generator for the RGB565-to-YCbCr/gray pipeline.
- Issues frame-buffer read addresses at one per active pixel and generates the vsync, hsync and de that accompany ram_data into the pipeline.
- Accounts for the one-cycle RAM read latency.
- Handles start, continuous and stop control, and signals frame completion to the bus-side controller.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch cycles
H_SYNC, 96, hsync width cycles
H_BP, 48, horizontal back porch cycles
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch lines
V_SYNC, 2, vsync width lines
V_BP, 33, vertical back porch lines
ADDR_W, 19, frame-buffer read address width
PIPE_LAT, 3, downstream pipeline latency in cycles, used for drain

Ports:
clk  in  1  module clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
cont  in  1  level; 1 = run frames back to back
stop  in  1  one-cycle pulse; finish the current frame, then stop
base_addr  in  ADDR_W  frame base address, sampled at each frame start
ram_rd_en  out  1  read strobe to frame buffer; data is returned the next cycle
ram_rd_addr  out  ADDR_W  read address
pre_frame_vsync  out  1  vsync to pipeline, active-high
pre_frame_hsync  out  1  hsync to pipeline, active-high
pre_frame_de  out  1  data enable to pipeline, aligned with ram_data
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at end of each frame

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1 are registered.
- Line order: sync, back porch, active, front porch. Frame order is the same.
- Slot timing terms:
  - hs = h_cnt < H_SYNC
  - vs = v_cnt < V_SYNC
  - act = H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE, and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE
- States: IDLE, RUN, DRAIN.
- IDLE:
  - Counters are held at 0.
  - start=1: go to RUN, h_cnt=v_cnt=0, addr<=base_addr.
  - stop is ignored.
- RUN, each cycle:
  - ram_rd_en = act (combinational from registered state and counters). ram_rd_addr = addr register.
  - addr increments by 1 on each ram_rd_en, modulo 2^ADDR_W.
  - h_cnt advances; when it wraps, v_cnt advances.
  - stop=1 sets sticky stop_pend.
  - start is ignored.
- Output alignment: pre_frame_vsync/hsync/de are registered copies of vs/hs/act (0 outside RUN). They lag ram_rd_en by exactly 1 cycle, so de coincides with the returned ram_data.
- Last slot of a frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1):
  - If cont=1 and stop_pend=0 (stop sampled in this same cycle counts as pending): wrap to 0,0, addr<=base_addr (re-sampled), stay in RUN. There is no gap cycle.
  - Otherwise go to DRAIN.
- frame_done is a registered pulse in the cycle after every last slot, whether the frame wraps or drains.
- DRAIN:
  - Lasts PIPE_LAT+1 cycles, then goes to IDLE.
  - stop_pend clears on entering IDLE.
  - start, stop and cont are ignored.
  - ram_rd_en=0. Sync outputs are 0 after the first DRAIN cycle, which carries the registered last slot.
- busy is combinational from state.
- Reset, at any time including mid-frame: state=IDLE, counters=0, addr=0, stop_pend=0. Every output is 0 (ram_rd_en, ram_rd_addr, pre_frame_vsync/hsync/de, busy, frame_done). No frame_done is issued for an aborted frame.
- hsync toggles on every line, including vertical blanking lines. vsync is high for whole lines, across all h_cnt.
- Parameters must all be >=1. Widths of h_cnt and v_cnt are clog2 of the totals.

Test Plan:
Small-parameter setup: H 4/1/1/1 (H_TOTAL=7), V 3/1/1/1 (V_TOTAL=6), PIPE_LAT=3. T0 is the first RUN cycle.
1. start, base_addr=0x100, cont=0 ->
   - first ram_rd_en at T0+16 with addr 0x100.
   - 12 reads, 0x100..0x10B, in rows at T0+16..19, T0+23..26, T0+30..33.
   - pre_frame_de high at T0+17..20, T0+24..27, T0+31..34.
   - frame_done at T0+42; busy low from T0+46.
2. Sync shape ->
   - pre_frame_vsync high T0+1..T0+7.
   - pre_frame_hsync high at T0+1+7k for k=0..5.
   - all outputs 0 in IDLE.
3. cont=1, base_addr changed to 0x200 mid-frame ->
   - second frame starts at T0+42 with no gap.
   - second frame first address is 0x200.
   - frame_done at T0+42 and T0+84.
4. cont=1, stop pulse at T0+20 ->
   - frame completes with all 12 pixels.
   - frame_done at T0+42, then DRAIN, busy low at T0+46.
   - start at T0+43 is ignored; no second frame.
5. rst asserted at T0+25 ->
   - all outputs 0 immediately; no frame_done.
   - next start restarts from base_addr with 12 reads.
6. base_addr=2^ADDR_W-4 ->
   - addresses wrap modulo 2^ADDR_W: ...FC..FF, then 0x000..0x007.
